pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 8-bit pipelined processor. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use stalls and taken-branch flushes, and runs the external-interrupt entry sequence: drain, push return PC, load vector. It sits in the top-level beside the hazard/forwarding logic and is the single owner of pipeline stall/flush decisions.

## Interface
Parameters:
- DRAIN_CYC, default 3: cycles spent in DRAIN so that in-flight EX/MEM/WB instructions retire; legal range 1–7.
- INT_VEC_SEL, default 2'd2: pc_sel code that selects the interrupt-vector source (M[1]).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ld_use_hazard  in  1  the instruction in ID/EX is a load whose destination matches a source of the instruction in ID.
- branch_taken  in  1  branch/jump resolved taken in EX.
- br_target  in  8  target PC of the taken branch.
- id_pc  in  8  PC of the instruction currently in ID.
- intr_req  in  1  external interrupt request, level.
- rti_ex  in  1  RTI instruction in EX; clears the interrupt mask.
- pc_en  out  1  PC write enable.
- pc_sel  out  2  PC source: 0 = pc+1, 1 = br_target, INT_VEC_SEL = vector.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear to bubble.
- id_ex_flush  out  1  ID/EX clear to bubble.
- ex_mem_flush  out  1  EX/MEM clear to bubble. Reserved; driven 0 in this revision.
- push_req  out  1  forces a stack push in MEM of push_data.
- push_data  out  8  return PC to be pushed.
- intr_ack  out  1  one-cycle acknowledge to the interrupt source.
- busy  out  1  high whenever state ≠ RUN.

## Operation
- FSM states: RUN, DRAIN, SAVE, VECTOR. Internal registers: 3-bit drain counter, 8-bit ret_pc, 1-bit int_mask.
- Reset (rst high at a clock edge) sets state to RUN, counter to 0, ret_pc to 0x00, int_mask to 0.
- While rst is high, outputs are forced: pc_en = 0, if_id_en = 0, if_id_flush = 1, id_ex_flush = 1, and all other outputs 0.
- Reset asserted mid-sequence aborts the sequence immediately at the next edge. No push is issued.

RUN behaviour (Mealy outputs), in priority order:
1. intr_req & !int_mask & !branch_taken: go to DRAIN.
   - Capture ret_pc ← id_pc.
   - pc_en = 0, if_id_flush = 1, id_ex_flush = 1.
   - Counter ← DRAIN_CYC-1.
2. branch_taken: pc_sel = 1, pc_en = 1, if_id_flush = 1, id_ex_flush = 1.
   - The load-use stall is ignored.
   - A pending interrupt waits one cycle. It is then taken with ret_pc = id_pc, which is the branch target's fetch.
3. ld_use_hazard: pc_en = 0, if_id_en = 0, id_ex_flush = 1 (one bubble).
4. Otherwise: pc_en = 1, pc_sel = 0, if_id_en = 1, no flushes.

DRAIN:
- pc_en = 0, if_id_flush = 1, id_ex_flush = 1.
- Counter decrements each cycle. At counter = 0, go to SAVE.
- A branch_taken seen in DRAIN (the branch was already in EX at entry) overwrites ret_pc ← br_target.

SAVE:
- One cycle: push_req = 1, push_data = ret_pc.
- pc_en = 0, flushes held.
- Next state: VECTOR.

VECTOR:
- One cycle: pc_sel = INT_VEC_SEL, pc_en = 1, intr_ack = 1, if_id_flush = 1.
- Sets int_mask ← 1. Next state: RUN.

Mask behaviour:
- rti_ex in RUN clears int_mask at the next edge.
- rti_ex and intr_req in the same cycle: the mask clear takes effect first, so the interrupt is taken in the following cycle.
- While int_mask = 1, intr_req is ignored (it is level, so it stays pending).

Other rules:
- intr_req dropping after DRAIN entry does not abort the sequence.
- busy = (state ≠ RUN).

## Timing
- Stall/flush outputs are combinational from the current state and inputs. There is no added latency; they act on the same edge as the hazard.
- Interrupt entry latency, from the intr_req sample to the vector PC load: DRAIN_CYC + 2 cycles. The vector load happens at the VECTOR edge.
- push_req is high for exactly one cycle per interrupt.
- intr_ack is high for exactly one cycle, in the VECTOR cycle.
- ld_use_hazard held high for N cycles produces an N-cycle stall. There is no internal limit.

## Test plan
- Load-use: ld_use_hazard = 1 for one cycle in RUN -> that cycle pc_en = 0, if_id_en = 0, id_ex_flush = 1; next cycle pc_en = 1, no flush.
- Branch vs stall: branch_taken = 1, br_target = 0x40, ld_use_hazard = 1 -> pc_sel = 1, pc_en = 1, if_id_flush = id_ex_flush = 1; next PC is 0x40.
- Interrupt, DRAIN_CYC = 3:
  - Stimulus: intr_req = 1, id_pc = 0x23.
  - DRAIN lasts 3 cycles; SAVE has push_req = 1, push_data = 0x23; VECTOR has pc_sel = 2, intr_ack = 1.
  - busy is high for 5 cycles.
- Branch during DRAIN: branch_taken = 1, br_target = 0x77 in DRAIN cycle 1 -> push_data = 0x77.
- Mask: second intr_req before rti_ex -> no DRAIN entry; after rti_ex pulse -> DRAIN entered on the next cycle.
- Reset mid-sequence: rst = 1 in SAVE -> next cycle state RUN, push_req = 0, int_mask = 0, ret_pc = 0x00.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: single owner of the pipeline's stall and flush decisions.
// It drives the PC and IF/ID, ID/EX, EX/MEM enable and flush controls. It resolves
// load-use stalls and taken-branch flushes, and runs the interrupt entry sequence
// (RUN -> DRAIN -> SAVE -> VECTOR).
// Ports:
//   inputs : clk, rst, ld_use_hazard, branch_taken, br_target, id_pc, intr_req, rti_ex
//   outputs: pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
//            push_req, push_data, intr_ack, busy
// All outputs are combinational from the current state and inputs (zero latency).
module pipe_hazard_ctrl #(
  parameter int         DRAIN_CYC   = 3,
  parameter logic [1:0] INT_VEC_SEL = 2'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_use_hazard,
  input  logic       branch_taken,
  input  logic [7:0] br_target,
  input  logic [7:0] id_pc,
  input  logic       intr_req,
  input  logic       rti_ex,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       push_req,
  output logic [7:0] push_data,
  output logic       intr_ack,
  output logic       busy
);

  typedef enum logic [1:0] {RUN, DRAIN, SAVE, VECTOR} state_t;

  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYC - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] ret_pc, ret_pc_nxt;
  logic       int_mask, int_mask_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 3'd0;
      ret_pc   <= 8'h00;
      int_mask <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ret_pc   <= ret_pc_nxt;
      int_mask <= int_mask_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ret_pc_nxt   = ret_pc;
    int_mask_nxt = int_mask;
    pc_en        = 1'b0;
    pc_sel       = 2'd0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    push_req     = 1'b0;
    push_data    = 8'h00;
    intr_ack     = 1'b0;
    busy         = 1'b0;

    if (rst) begin
      // While in reset, hold the front of the pipe empty. The registers are reset by the always_ff block.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      busy = (state != RUN);
      case (state)
        RUN: begin
          // A taken branch outranks the interrupt. Then the interrupt is taken next cycle,
          // and id_pc holds the branch target's fetch.
          if (intr_req && !int_mask && !branch_taken) begin
            state_nxt   = DRAIN;
            ret_pc_nxt  = id_pc;
            cnt_nxt     = CNT_INIT;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (branch_taken) begin
            pc_sel      = 2'd1;
            pc_en       = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ld_use_hazard) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
          if (rti_ex) int_mask_nxt = 1'b0;
        end
        DRAIN: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          // The branch was already in EX when we entered, so execution resumes at its target.
          if (branch_taken) ret_pc_nxt = br_target;
          if (cnt == 3'd0) state_nxt = SAVE;
          else             cnt_nxt   = cnt - 3'd1;
        end
        SAVE: begin
          push_req    = 1'b1;
          push_data   = ret_pc;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt   = VECTOR;
        end
        VECTOR: begin
          pc_sel       = INT_VEC_SEL;
          pc_en        = 1'b1;
          intr_ack     = 1'b1;
          if_id_flush  = 1'b1;
          int_mask_nxt = 1'b1;
          state_nxt    = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. The driver applies directed and random inputs.
// A reference model expects the outputs of each cycle and queues them. A monitor on the
// falling edge pops the expected values and compares them with the DUT outputs.
module tb_pipe_hazard_ctrl;
  localparam int DRAIN_CYC = 3;

  logic       clk = 1'b0;
  logic       rst, ld_use_hazard, branch_taken, intr_req, rti_ex;
  logic [7:0] br_target, id_pc;
  logic       pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic       push_req, intr_ack, busy;
  logic [1:0] pc_sel;
  logic [7:0] push_data;

  pipe_hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC), .INT_VEC_SEL(2'd2)) dut (
    .clk(clk), .rst(rst), .ld_use_hazard(ld_use_hazard), .branch_taken(branch_taken),
    .br_target(br_target), .id_pc(id_pc), .intr_req(intr_req), .rti_ex(rti_ex),
    .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .push_req(push_req),
    .push_data(push_data), .intr_ack(intr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bit order: pc_en, pc_sel[1:0], if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
  // push_req, intr_ack, busy
  logic [9:0] exp_q[$];
  logic [7:0] push_q[$];
  int compared = 0, mismatched = 0;
  int exp_acks = 0, got_acks = 0;

  // Reference model state. seq_left counts the interrupt-sequence cycles still to run.
  // A value of 0 means normal running.
  int       seq_left = 0;
  bit       mask = 0;
  bit [7:0] saved = 8'h00;

  task automatic step(input bit r, input bit ld, input bit br, input bit [7:0] tgt,
                      input bit [7:0] pc, input bit ir, input bit rti);
    bit       e_pc_en, e_ifid_en, e_ifid_fl, e_idex_fl, e_push, e_ack, e_busy;
    bit [1:0] e_sel;
    rst = r; ld_use_hazard = ld; branch_taken = br; br_target = tgt;
    id_pc = pc; intr_req = ir; rti_ex = rti;
    {e_pc_en, e_sel, e_ifid_en, e_ifid_fl, e_idex_fl, e_push, e_ack, e_busy} = '0;
    if (r) begin
      e_ifid_fl = 1; e_idex_fl = 1;
      seq_left = 0; mask = 0; saved = 8'h00;
    end else if (seq_left == 0) begin
      if (ir && !mask && !br) begin
        e_ifid_fl = 1; e_idex_fl = 1;
        saved = pc; seq_left = DRAIN_CYC + 2;
      end else if (br) begin
        e_pc_en = 1; e_sel = 2'd1; e_ifid_fl = 1; e_idex_fl = 1;
      end else if (ld) begin
        e_idex_fl = 1;
      end else begin
        e_pc_en = 1; e_ifid_en = 1;
      end
      if (rti) mask = 0;
    end else begin
      e_busy = 1;
      if (seq_left > 2) begin
        e_ifid_fl = 1; e_idex_fl = 1;
        if (br) saved = tgt;
      end else if (seq_left == 2) begin
        e_push = 1; e_ifid_fl = 1; e_idex_fl = 1;
        push_q.push_back(saved);
      end else begin
        e_pc_en = 1; e_sel = 2'd2; e_ack = 1; e_ifid_fl = 1;
        mask = 1; exp_acks++;
      end
      seq_left--;
    end
    exp_q.push_back({e_pc_en, e_sel, e_ifid_en, e_ifid_fl, e_idex_fl, 1'b0, e_push, e_ack, e_busy});
  endtask

  task automatic tick(input bit r, input bit ld, input bit br, input bit [7:0] tgt,
                      input bit [7:0] pc, input bit ir, input bit rti);
    @(posedge clk); #1;
    step(r, ld, br, tgt, pc, ir, rti);
  endtask

  // Monitor: the outputs are combinational, so the DUT presents a result every cycle.
  always @(negedge clk) begin
    logic [9:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, push_req, intr_ack, busy};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs t=%0t got=%b expected=%b (pc_en,sel,ifid_en,ifid_fl,idex_fl,exmem_fl,push,ack,busy)",
                 $time, a, e);
      end
      if (push_req === 1'b1) begin
        compared++;
        if (push_q.size() == 0) begin
          mismatched++;
          $display("FAIL push_unexpected t=%0t got push_data=%h expected no push", $time, push_data);
        end else begin
          logic [7:0] ep;
          ep = push_q.pop_front();
          if (push_data !== ep) begin
            mismatched++;
            $display("FAIL push_data t=%0t got=%h expected=%h", $time, push_data, ep);
          end
        end
      end
      if (intr_ack === 1'b1) got_acks++;
    end
  end

  initial begin
    rst = 1; ld_use_hazard = 0; branch_taken = 0; br_target = 0; id_pc = 0;
    intr_req = 0; rti_ex = 0;
    // Reset, then the load-use stall and the branch that wins over a stall.
    tick(1, 0, 0, 8'h00, 8'h00, 0, 0);
    tick(1, 1, 1, 8'h12, 8'h34, 1, 0);
    tick(0, 0, 0, 8'h00, 8'h10, 0, 0);
    tick(0, 1, 0, 8'h00, 8'h11, 0, 0);
    tick(0, 0, 0, 8'h00, 8'h11, 0, 0);
    tick(0, 1, 1, 8'h40, 8'h12, 0, 0);
    tick(0, 0, 0, 8'h00, 8'h40, 0, 0);
    // Interrupt at id_pc 0x23. Sequence: DRAIN x3, SAVE (push 0x23), VECTOR.
    tick(0, 0, 0, 8'h00, 8'h23, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 8'h00, 8'h50, 0, 0);
    // Masked: a held request is ignored. Then rti and intr in the same cycle, then entry.
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 8'h00, 8'h60, 1, 0);
    tick(0, 0, 0, 8'h00, 8'h61, 1, 1);
    tick(0, 0, 0, 8'h00, 8'h62, 1, 0);
    // A branch in the first DRAIN cycle redirects the saved PC to 0x77.
    tick(0, 0, 1, 8'h77, 8'h63, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 8'h00, 8'h64, 0, 0);
    // The mask is set again, so clear it. A branch then defers a pending interrupt by one cycle.
    tick(0, 0, 0, 8'h00, 8'h65, 0, 1);
    tick(0, 0, 1, 8'h90, 8'h66, 1, 0);
    tick(0, 0, 0, 8'h00, 8'h90, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 8'h00, 8'h91, 0, 0);
    // Reset in SAVE aborts the sequence, so no push is issued.
    tick(0, 0, 0, 8'h00, 8'h92, 0, 1);
    tick(0, 0, 0, 8'h00, 8'hA5, 1, 0);
    for (int i = 0; i < DRAIN_CYC; i++) tick(0, 0, 0, 8'h00, 8'hA6, 0, 0);
    tick(1, 0, 0, 8'h00, 8'hA7, 0, 0);
    tick(0, 0, 0, 8'h00, 8'hA8, 0, 0);
    tick(0, 0, 0, 8'h00, 8'hA9, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 8'h00, 8'hAA, 0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
           8'($urandom), 8'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
    tick(0, 0, 0, 8'h00, 8'h00, 0, 0);
    // Let the monitor drain the queue, waiting a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
    compared++;
    if (push_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_push got %0d unpushed expected 0", push_q.size());
    end
    compared++;
    if (got_acks != exp_acks) begin
      mismatched++;
      $display("FAIL ack_count got=%0d expected=%0d", got_acks, exp_acks);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
